// File: rtl/serial_unpacker.sv
// Rebuilds the A and B parallel words from two LSB-first serial lanes and offers them with a Valid/Ack handshake.
// Define UNPACKER_PARITY_EN to expect a trailing even-parity bit per lane and report mismatches on Par_Err.
module serial_unpacker #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 2)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic             A_In,
  input  logic             B_In,
  input  logic             Ack,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun,
  output logic             Par_Err,
  output logic [CW-1:0]    Bit_Count,
  output logic [1:0]       state_dbg
);

  // Handshake: Valid stays high while a frame is held; the consumer pulses Ack
  // for one cycle to release it, and Valid drops on the following edge.

`ifdef UNPACKER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   clr;
  logic   take_bit;
  logic   shift_data;
  logic   overrun_set;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clr         = 1'b0;
    take_bit    = 1'b0;
    shift_data  = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = CAPTURE;
          clr       = 1'b1;
        end
      end
      CAPTURE: begin
        // A restart wins over a bit arriving in the same cycle.
        if (Start) begin
          clr = 1'b1;
        end else if (Shift_En) begin
          take_bit   = 1'b1;
          shift_data = (Bit_Count < CW'(WIDTH));
          if (Bit_Count == CW'(FRAME_BITS - 1)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        overrun_set = Shift_En;
        if (Ack) begin
          if (Start) begin
            state_nxt = CAPTURE;
            clr       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      A         <= '0;
      B         <= '0;
      Bit_Count <= '0;
      Overrun   <= 1'b0;
    end else begin
      if (clr) begin
        A         <= '0;
        B         <= '0;
        Bit_Count <= '0;
      end else if (take_bit) begin
        Bit_Count <= Bit_Count + CW'(1);
        if (shift_data) begin
          A <= {A_In, A[WIDTH-1:1]};
          B <= {B_In, B[WIDTH-1:1]};
        end
      end
      if (overrun_set) Overrun <= 1'b1;
    end
  end

`ifdef UNPACKER_PARITY_EN
  logic enter_hold;
  assign enter_hold = (state == CAPTURE) && (state_nxt == HOLD);

  // The incoming bit on the entering edge is the parity bit; A/B already hold the data.
  always_ff @(posedge Clk) begin
    if (Reset)           Par_Err <= 1'b0;
    else if (clr)        Par_Err <= 1'b0;
    else if (enter_hold) Par_Err <= (^A ^ A_In) | (^B ^ B_In);
  end
`else
  assign Par_Err = 1'b0;
`endif

  assign Valid     = (state == HOLD);
  assign Busy      = (state == CAPTURE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_unpacker.sv
// Bench for serial_unpacker: frame-level model (bit lists per lane), per-cycle compare, frame scoreboard, directed plus random stimulus.
module tb_serial_unpacker;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 2);
`ifdef UNPACKER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             Shift_En = 1'b0;
  logic             A_In = 1'b0;
  logic             B_In = 1'b0;
  logic             Ack = 1'b0;
  logic [WIDTH-1:0] A, B;
  logic             Valid, Busy, Overrun, Par_Err;
  logic [CW-1:0]    Bit_Count;
  logic [1:0]       state_dbg;

  serial_unpacker #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Shift_En(Shift_En),
    .A_In(A_In), .B_In(B_In), .Ack(Ack),
    .A(A), .B(B), .Valid(Valid), .Busy(Busy), .Overrun(Overrun),
    .Par_Err(Par_Err), .Bit_Count(Bit_Count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // frame-level model: mode 0 idle, 1 collecting, 2 frame held
  int               m_mode = 0;
  int               m_n = 0;
  logic [WIDTH-1:0] m_abits = '0;
  logic [WIDTH-1:0] m_bbits = '0;
  logic             m_pa = 1'b0;
  logic             m_pb = 1'b0;
  logic             m_ov = 1'b0;
  logic             m_pe = 1'b0;
  logic             prev_valid = 1'b0;

  logic [2*WIDTH-1:0] exp_q[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic new_frame();
    m_mode  = 1;
    m_n     = 0;
    m_abits = '0;
    m_bbits = '0;
    m_pe    = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (Reset) begin
      m_mode = 0; m_n = 0; m_abits = '0; m_bbits = '0; m_ov = 1'b0; m_pe = 1'b0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (Start) new_frame();
        1: begin
          if (Start) new_frame();
          else if (Shift_En) begin
            if (m_n < WIDTH) begin
              m_abits[m_n] = A_In;
              m_bbits[m_n] = B_In;
            end else begin
              m_pa = A_In;
              m_pb = B_In;
            end
            m_n++;
            if (m_n == FRAME) begin
              m_mode = 2;
              exp_q.push_back({m_abits, m_bbits});
`ifdef UNPACKER_PARITY_EN
              m_pe = (^m_abits ^ m_pa) | (^m_bbits ^ m_pb);
`endif
            end
          end
        end
        default: begin
          if (Shift_En) m_ov = 1'b1;
          if (Ack) begin
            if (Start) new_frame();
            else m_mode = 0;
          end
        end
      endcase
    end
  endtask

  // Per-cycle compare: k collected bits sit in the top k positions of each word.
  task automatic check_all();
    int                 k;
    logic [WIDTH-1:0]   ea, eb;
    logic [2*WIDTH-1:0] w;
    k  = (m_n < WIDTH) ? m_n : WIDTH;
    ea = m_abits << (WIDTH - k);
    eb = m_bbits << (WIDTH - k);
    cmp("A", 32'(A), 32'(ea));
    cmp("B", 32'(B), 32'(eb));
    cmp("Valid", 32'(Valid), 32'(m_mode == 2));
    cmp("Busy", 32'(Busy), 32'(m_mode == 1));
    cmp("Overrun", 32'(Overrun), 32'(m_ov));
    cmp("Par_Err", 32'(Par_Err), 32'(m_pe));
    cmp("Bit_Count", 32'(Bit_Count), 32'(m_n));
    if (Valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_unexpected: Valid rose with no frame expected at %0t", $time);
      end else begin
        w = exp_q.pop_front();
        cmp("frame_A", 32'(A), 32'(w[2*WIDTH-1:WIDTH]));
        cmp("frame_B", 32'(B), 32'(w[WIDTH-1:0]));
      end
    end
    prev_valid = Valid;
  endtask

  // driver tasks
  task automatic step(input logic st, input logic sh, input logic ai, input logic bi,
                      input logic ak, input logic rs);
    Start = st; Shift_En = sh; A_In = ai; B_In = bi; Ack = ak; Reset = rs;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic pa, input logic pb, input int maxgap);
    for (int i = 0; i < FRAME; i++) begin
      int g;
      g = $urandom_range(maxgap, 0);
      repeat (g) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (i < WIDTH) step(1'b0, 1'b1, a[i], b[i], 1'b0, 1'b0);
      else           step(1'b0, 1'b1, pa, pb, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int maxgap);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(a, b, ^a, ^b, maxgap);
  endtask

  initial begin
    @(negedge Clk);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a capture
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("pin_rst_A", 32'(A), 32'h0);
    cmp("pin_rst_cnt", 32'(Bit_Count), 32'h0);
    cmp("pin_rst_busy", 32'(Busy), 32'h0);

    // back-to-back frame
    send_frame(8'hA5, 8'h3C, 0);
    cmp("pin_A5", 32'(A), 32'hA5);
    cmp("pin_3C", 32'(B), 32'h3C);
    cmp("pin_valid", 32'(Valid), 32'h1);
    cmp("pin_busy_hold", 32'(Busy), 32'h0);
    cmp("pin_model_A5", 32'(m_abits), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // same frame with gaps between bits
    send_frame(8'hA5, 8'h3C, 3);
    cmp("pin_gap_A", 32'(A), 32'hA5);
    cmp("pin_gap_B", 32'(B), 32'h3C);

    // overrun while holding
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("pin_ovr_A", 32'(A), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("pin_ovr", 32'(Overrun), 32'h1);
    cmp("pin_ack_valid", 32'(Valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("pin_ovr_start", 32'(Overrun), 32'h1);

    // Start together with Ack goes straight back to capture
    send_bits(8'h11, 8'h22, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("pin_sa_busy", 32'(Busy), 32'h1);
    send_bits(8'hFF, 8'h01, 1'b0, 1'b1, 0);
    cmp("pin_FF", 32'(A), 32'hFF);
    cmp("pin_01", 32'(B), 32'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef UNPACKER_PARITY_EN
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hA5, 8'h3C, 1'b0, 1'b1, 0);
    cmp("pin_perr1", 32'(Par_Err), 32'h1);
    cmp("pin_perr_A", 32'(A), 32'hA5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'hA5, 8'h3C, 1'b0, 1'b0, 0);
    cmp("pin_perr0", 32'(Par_Err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(15, 0) == 0), 1'($urandom_range(1, 0)), 1'($urandom), 1'($urandom),
           1'($urandom_range(5, 0) == 0), 1'($urandom_range(150, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
